// File: rtl/stream_rr_arbiter_pkg.sv
// Shared constants and helpers for the stream round-robin arbiter.
// Holds the default parameter values, the ID-width function and the
// reset value of the last-grant pointer.
package stream_rr_arbiter_pkg;

    localparam int RR_DEF_DW        = 32;
    localparam int RR_DEF_N         = 4;
    localparam int RR_DEF_MAX_BURST = 4;

    // Width of a port index: max(1, clog2(n)).
    function automatic int rr_idw(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // last_grant starts at the highest port so that the first search
    // after reset begins at port 0.
    function automatic int rr_last_grant_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the upstream (N requesters) and downstream stream signals.
// The arbiter uses the slave modport; the environment driving requests
// and sinking beats uses the master modport.
interface stream_rr_arbiter_if #(
    parameter int DW = stream_rr_arbiter_pkg::RR_DEF_DW,
    parameter int N  = stream_rr_arbiter_pkg::RR_DEF_N
);
    import stream_rr_arbiter_pkg::*;

    localparam int IDW = rr_idw(N);

    logic [N-1:0]    up_valid;
    logic [N*DW-1:0] up_data;
    logic [N-1:0]    up_ready;
    logic            down_valid;
    logic [DW-1:0]   down_data;
    logic [IDW-1:0]  down_id;
    logic            down_ready;

    modport slave (
        input  up_valid,
        input  up_data,
        output up_ready,
        output down_valid,
        output down_data,
        output down_id,
        input  down_ready
    );

    modport master (
        output up_valid,
        output up_data,
        input  up_ready,
        input  down_valid,
        input  down_data,
        input  down_id,
        output down_ready
    );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// searching last+1, last+2, ... modulo N (last itself is tried last).
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           gnt_valid_o
);

    int idx_s;

    // Rotating priority search, first hit wins.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx_s       = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(last_i) + k) % N;
            if (!gnt_valid_o && req_i[idx_s]) begin
                gnt_valid_o  = 1'b1;
                gnt_o[idx_s] = 1'b1;
                gnt_idx_o    = IDW'(idx_s);
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 stream round-robin arbiter with a registered output stage.
// Optional feature macro RR_ARB_BURST_EN: the last winner keeps priority
// for up to MAX_BURST consecutive accepted beats while it stays valid.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int DW        = RR_DEF_DW,
    parameter int N         = RR_DEF_N,
    parameter int MAX_BURST = RR_DEF_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_rr_arbiter_if.slave   bus
);

    localparam int             IDW      = rr_idw(N);
    localparam logic [IDW-1:0] LAST_RST = IDW'(rr_last_grant_rst(N));

    if (N < 2 || N > 16) begin : g_bad_n
        $error("stream_rr_arbiter: N must be in 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("stream_rr_arbiter: MAX_BURST must be in 1..255");
    end

    // Output register and arbitration state
    logic           down_valid_q, down_valid_d;
    logic [DW-1:0]  down_data_q,  down_data_d;
    logic [IDW-1:0] down_id_q,    down_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;

    // Winner selection
    logic           load_s;
    logic [N-1:0]   pick_gnt_s;
    logic [IDW-1:0] pick_idx_s;
    logic           pick_valid_s;
    logic [N-1:0]   win_gnt_s;
    logic [IDW-1:0] win_idx_s;
    logic           win_valid_s;
    logic [DW-1:0]  win_data_s;

`ifdef RR_ARB_BURST_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       hold_s;
`endif

    // The output stage can take a new beat when empty or being drained.
    assign load_s = !down_valid_q || bus.down_ready;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i       (bus.up_valid),
        .last_i      (last_grant_q),
        .gnt_o       (pick_gnt_s),
        .gnt_idx_o   (pick_idx_s),
        .gnt_valid_o (pick_valid_s)
    );

`ifdef RR_ARB_BURST_EN
    // Burst holder keeps priority while valid and under its beat budget.
    always_comb begin
        hold_s = (burst_cnt_q != 8'd0) && (burst_cnt_q < BURST_LIMIT)
                 && bus.up_valid[last_grant_q];
        if (hold_s) begin
            win_valid_s = 1'b1;
            win_idx_s   = last_grant_q;
            win_gnt_s   = {{(N-1){1'b0}}, 1'b1} << last_grant_q;
        end else begin
            win_valid_s = pick_valid_s;
            win_idx_s   = pick_idx_s;
            win_gnt_s   = pick_gnt_s;
        end
    end
`else
    // Plain rotation: the picker alone decides.
    always_comb begin
        win_valid_s = pick_valid_s;
        win_idx_s   = pick_idx_s;
        win_gnt_s   = pick_gnt_s;
    end
`endif

    // Select the winner's data word.
    always_comb begin
        win_data_s = bus.up_data[int'(win_idx_s)*DW +: DW];
    end

    // Handshake back to requesters: only the winner, only on load cycles.
    always_comb begin
        bus.up_ready = '0;
        if (!rst && load_s && win_valid_s) begin
            bus.up_ready = win_gnt_s;
        end else begin
            bus.up_ready = '0;
        end
    end

    // Next state of output stage and arbitration pointer.
    always_comb begin
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_id_d    = down_id_q;
        last_grant_d = last_grant_q;
`ifdef RR_ARB_BURST_EN
        burst_cnt_d  = burst_cnt_q;
`endif
        if (load_s) begin
            if (win_valid_s) begin
                down_valid_d = 1'b1;
                down_data_d  = win_data_s;
                down_id_d    = win_idx_s;
                last_grant_d = win_idx_s;
`ifdef RR_ARB_BURST_EN
                burst_cnt_d  = hold_s ? (burst_cnt_q + 8'd1) : 8'd1;
`endif
            end else begin
                down_valid_d = 1'b0;
`ifdef RR_ARB_BURST_EN
                burst_cnt_d  = 8'd0;
`endif
            end
        end else begin
            down_valid_d = down_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_id_q    <= '0;
            last_grant_q <= LAST_RST;
`ifdef RR_ARB_BURST_EN
            burst_cnt_q  <= 8'd0;
`endif
        end else begin
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_id_q    <= down_id_d;
            last_grant_q <= last_grant_d;
`ifdef RR_ARB_BURST_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign bus.down_valid = down_valid_q;
    assign bus.down_data  = down_data_q;
    assign bus.down_id    = down_id_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (N=4, DW=32, MAX_BURST=3).
// Works for both the default build and RR_ARB_BURST_EN.
module tb_stream_rr_arbiter;

    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int MB  = 3;
    localparam int IDW = 2;
`ifdef RR_ARB_BURST_EN
    localparam bit BURST = 1'b1;
    localparam int FAIR  = N * MB;
`else
    localparam bit BURST = 1'b0;
    localparam int FAIR  = N;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.DW(DW), .N(N)) ifc ();

    stream_rr_arbiter #(
        .DW        (DW),
        .N         (N),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
    } beat_t;

    int             vectors = 0;
    int             miscompares = 0;
    beat_t          sbq[$];
    int             m_last;
    int             m_cnt;
    bit             m_dv;
    logic [DW-1:0]  m_data;
    logic [IDW-1:0] m_id;
    logic [DW-1:0]  cur_data[N];
    int             seq[N];
    int             waitc[N];
    logic [N-1:0]   v;
    bit             dr;
    int             tbl[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen_data(input int p, input int s);
        return {4'hC, 4'(p), 24'(s)};
    endfunction

    function automatic bit model_hold(input logic [N-1:0] vv);
        return BURST && (m_cnt > 0) && (m_cnt < MB) && vv[m_last];
    endfunction

    function automatic int model_pick(input logic [N-1:0] vv);
        if (model_hold(vv)) return m_last;
        for (int k = 1; k <= N; k++) begin
            if (vv[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_dv = 1'b0; m_data = '0; m_id = '0; m_last = N - 1; m_cnt = 0;
        sbq.delete();
        for (int p = 0; p < N; p++) waitc[p] = 0;
    endtask

    // One clock: drive at negedge, check up_ready, step model, check outputs.
    task automatic cycle();
        int           win;
        bit           ld;
        bit           hold;
        logic [N-1:0] er;
        beat_t        b;
        for (int p = 0; p < N; p++) ifc.up_data[p*DW +: DW] = cur_data[p];
        ifc.up_valid   = v;
        ifc.down_ready = dr;
        #1;
        ld   = !m_dv || dr;
        hold = model_hold(v);
        win  = (!rst && ld) ? model_pick(v) : -1;
        er   = '0;
        if (win >= 0) er[win] = 1'b1;
        chk("up_ready", ifc.up_ready, er);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (ld) begin
            if (win >= 0) begin
                sbq.push_back('{cur_data[win], IDW'(win)});
                m_cnt  = hold ? m_cnt + 1 : 1;
                m_last = win;
                m_dv   = 1'b1;
                for (int p = 0; p < N; p++) begin
                    if (p == win) waitc[p] = 0;
                    else if (v[p]) begin
                        waitc[p]++;
                        chk("fairness", (waitc[p] <= FAIR), 1);
                    end else waitc[p] = 0;
                end
                seq[win]++;
                cur_data[win] = gen_data(win, seq[win]);
                b      = sbq.pop_front();
                m_data = b.data;
                m_id   = b.id;
            end else begin
                m_dv  = 1'b0;
                m_cnt = 0;
            end
        end
        chk("down_valid", ifc.down_valid, m_dv);
        chk("down_data", ifc.down_data, m_data);
        chk("down_id", ifc.down_id, m_id);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        v   = '0;
        dr  = 1'b1;
        for (int p = 0; p < N; p++) begin
            seq[p] = 0;
            cur_data[p] = gen_data(p, 0);
        end
        model_reset();
        @(negedge clk);

        // Reset with all requesters valid: no ready, outputs cleared.
        v = '1;
        cycle();
        cycle();
        rst = 1'b0;

        // Steady rotation (or bursts of MB with two requesters).
`ifdef RR_ARB_BURST_EN
        v   = 4'b0011;
        tbl = '{0, 0, 0, 1, 1, 1, 0, 0};
`else
        v   = 4'b1111;
        tbl = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("seq_id", ifc.down_id, tbl[k]);
        end

        // Stall for five cycles with a beat pending, then release.
        v  = 4'b1111;
        dr = 1'b0;
        repeat (5) cycle();
        dr = 1'b1;
        cycle();
        cycle();

        // Single requester on port 2 with a fixed word.
        rst = 1'b1;
        v   = '0;
        cycle();
        rst = 1'b0;
        cur_data[2] = 32'hA5A5_0001;
        v = 4'b0100;
        cycle();
        chk("p2_data", ifc.down_data, 32'hA5A5_0001);
        chk("p2_id", ifc.down_id, 2'd2);
        v = '0;
        cycle();

        // Reset while a stalled beat is held; first grant goes to port 1.
        v  = 4'b1111;
        dr = 1'b1;
        cycle();
        dr = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_dv", ifc.down_valid, 1'b0);
        chk("rst_id", ifc.down_id, 2'd0);
        rst = 1'b0;
        dr  = 1'b1;
        v   = 4'b0110;
        cycle();
        chk("first_after_rst", ifc.down_id, 2'd1);

        // Random valid / ready traffic.
        repeat (400) begin
            for (int p = 0; p < N; p++) v[p] = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
